// File: rtl/readout_pkg.sv
// Shared readout definitions: channel limits, arbiter state encoding, clog2 helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package readout_pkg;

    localparam int ARB_MAX_CH = 16;
    localparam int OWNER_W    = 4;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    // Smallest r with 2**r >= v; v <= 0 or 1 gives 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set req bit strictly after 'last', wrapping mod WIDTH.
// Latency: purely combinational.
// Backpressure: none; caller decides whether the pick is used.
// Ports: req (request vector), last (previous winner), hit (any request), idx (winner).
module rr_pick
    import readout_pkg::*;
#(
    parameter int WIDTH = 7
) (
    input  logic [WIDTH-1:0]   req,
    input  logic [OWNER_W-1:0] last,
    output logic               hit,
    output logic [OWNER_W-1:0] idx
);

    // Scanning last+WIDTH down to last+1 and letting later matches override
    // leaves the nearest successor of 'last' as the winner; this is the same
    // result as rotate, priority-encode, unrotate. 'last' itself is the final
    // candidate so a lone requester is picked again.
    always_comb begin
        int pos;
        pos = 0;
        hit = 1'b0;
        idx = last;
        for (int k = WIDTH; k >= 1; k--) begin
            pos = (int'(last) + k) % WIDTH;
            if (req[pos]) begin
                hit = 1'b1;
                idx = OWNER_W'(pos);
            end
        end
    end

endmodule

// File: rtl/burst_rr_arbiter.sv
// Burst round-robin merger of WIDTH FWFT sources into one DATA_WIDTH stream.
// Latency: 1 cycle from READ_GRANT pop to WRITE_OUT/DATA_OUT.
// Backpressure: READY_OUT=0 suppresses every grant and freezes arbiter state.
// Ports: CLK/RST_N (sync active-low); CH_EN/WRITE_REQ/HOLD_REQ/DATA_IN per channel;
//        READ_GRANT one-hot pop; READY_OUT downstream ready; WRITE_OUT/DATA_OUT
//        registered word; OWNER/LOCKED ownership status; WORD_CNT/CNT_CLR word counter.
module burst_rr_arbiter
    import readout_pkg::*;
#(
    parameter int WIDTH      = 7,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4,
    parameter int TAG_BITS   = 0,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic [WIDTH-1:0]            CH_EN,
    input  logic [WIDTH-1:0]            WRITE_REQ,
    input  logic [WIDTH-1:0]            HOLD_REQ,
    input  logic [WIDTH*DATA_WIDTH-1:0] DATA_IN,
    output logic [WIDTH-1:0]            READ_GRANT,
    input  logic                        READY_OUT,
    output logic                        WRITE_OUT,
    output logic [DATA_WIDTH-1:0]       DATA_OUT,
    output logic [3:0]                  OWNER,
    output logic                        LOCKED,
    output logic [CNT_WIDTH-1:0]        WORD_CNT,
    input  logic                        CNT_CLR
);

    if (WIDTH < 1 || WIDTH > ARB_MAX_CH) begin : g_bad_width
        $error("burst_rr_arbiter: WIDTH must be 1..16");
    end
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
        $error("burst_rr_arbiter: MAX_BURST must be 1..255");
    end
    if (TAG_BITS > 0 && (clog2(WIDTH) > TAG_BITS || TAG_BITS > DATA_WIDTH)) begin : g_bad_tag
        $error("burst_rr_arbiter: TAG_BITS too small for WIDTH or wider than DATA_WIDTH");
    end

    arb_state_t                state_q, state_d;
    logic [OWNER_W-1:0]        owner_q, owner_d;
    logic [7:0]                burst_q, burst_d;
    logic [ARB_MAX_CH-1:0]     en_w, req_w, hold_w, grant_w;
    logic [WIDTH-1:0]          elig;
    logic                      pick_hit;
    logic [OWNER_W-1:0]        pick_idx;
    logic                      cont;
    logic                      do_grant;
    logic [DATA_WIDTH-1:0]     sel_word;
    logic [DATA_WIDTH-1:0]     tagged_word;

    // Widen per-channel vectors so the 4-bit owner index is always in range.
    assign en_w   = ARB_MAX_CH'(CH_EN);
    assign req_w  = ARB_MAX_CH'(WRITE_REQ);
    assign hold_w = ARB_MAX_CH'(HOLD_REQ);
    assign elig   = WRITE_REQ & CH_EN;

    rr_pick #(.WIDTH(WIDTH)) u_pick (
        .req  (elig),
        .last (owner_q),
        .hit  (pick_hit),
        .idx  (pick_idx)
    );

    // Owner keeps the bus while enabled and either holding or under its burst quota.
    assign cont = (state_q == ARB_LOCK) && en_w[owner_q] &&
                  (hold_w[owner_q] || (burst_q < 8'(MAX_BURST)));

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        burst_d  = burst_q;
        do_grant = 1'b0;
        // Gating on RST_N keeps the reset cycle free of pops.
        if (RST_N && READY_OUT) begin
            if (cont && req_w[owner_q]) begin
                do_grant = 1'b1;
                // Saturate so a long hold never wraps back under MAX_BURST.
                burst_d  = (burst_q == 8'hFF) ? burst_q : burst_q + 8'd1;
            end else if (cont && hold_w[owner_q]) begin
                // Holding owner with an empty source: wait, keep the bus.
                state_d  = ARB_LOCK;
            end else if (pick_hit) begin
                // Same-cycle handover gives back-to-back bursts without a bubble.
                do_grant = 1'b1;
                owner_d  = pick_idx;
                burst_d  = 8'd1;
                state_d  = ARB_LOCK;
            end else begin
                state_d  = ARB_IDLE;
            end
        end
    end

    assign grant_w    = ARB_MAX_CH'(1) << owner_d;
    assign READ_GRANT = do_grant ? grant_w[WIDTH-1:0] : '0;
    assign sel_word   = DATA_IN[owner_d*DATA_WIDTH +: DATA_WIDTH];

    if (TAG_BITS > 0) begin : g_tag
        always_comb begin
            tagged_word = sel_word;
            tagged_word[DATA_WIDTH-1 -: TAG_BITS] = TAG_BITS'(owner_d);
        end
    end else begin : g_notag
        assign tagged_word = sel_word;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWNER_W'(WIDTH - 1);
            burst_q   <= 8'd0;
            WRITE_OUT <= 1'b0;
            DATA_OUT  <= '0;
            WORD_CNT  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            burst_q   <= burst_d;
            WRITE_OUT <= do_grant;
            if (do_grant) DATA_OUT <= tagged_word;
            // Clear wins over a same-cycle increment.
            if (CNT_CLR)
                WORD_CNT <= '0;
            else if (do_grant && (WORD_CNT != '1))
                WORD_CNT <= WORD_CNT + CNT_WIDTH'(1);
        end
    end

    assign OWNER  = owner_q;
    assign LOCKED = (state_q == ARB_LOCK);

endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Directed bench for burst_rr_arbiter (WIDTH=7, MAX_BURST=4, TAG_BITS=3, CNT_WIDTH=4).
// Latency: inputs driven at negedge, grants sampled 1 time unit later, outputs one cycle on.
// Backpressure: READY_OUT toggled in a dedicated scenario.
module tb_burst_rr_arbiter;

    logic         CLK;
    logic         RST_N;
    logic [6:0]   CH_EN;
    logic [6:0]   WRITE_REQ;
    logic [6:0]   HOLD_REQ;
    logic [223:0] DATA_IN;
    logic [6:0]   READ_GRANT;
    logic         READY_OUT;
    logic         WRITE_OUT;
    logic [31:0]  DATA_OUT;
    logic [3:0]   OWNER;
    logic         LOCKED;
    logic [3:0]   WORD_CNT;
    logic         CNT_CLR;

    int n_checks = 0;
    int n_fail   = 0;

    burst_rr_arbiter #(
        .WIDTH(7), .DATA_WIDTH(32), .MAX_BURST(4), .TAG_BITS(3), .CNT_WIDTH(4)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .CH_EN(CH_EN), .WRITE_REQ(WRITE_REQ),
        .HOLD_REQ(HOLD_REQ), .DATA_IN(DATA_IN), .READ_GRANT(READ_GRANT),
        .READY_OUT(READY_OUT), .WRITE_OUT(WRITE_OUT), .DATA_OUT(DATA_OUT),
        .OWNER(OWNER), .LOCKED(LOCKED), .WORD_CNT(WORD_CNT), .CNT_CLR(CNT_CLR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected output word: channel index in bits [31:29], source bits below.
    function automatic logic [31:0] exp_word(input int ch);
        logic [31:0] w;
        logic [2:0]  t;
        w = DATA_IN[ch*32 +: 32];
        t = 3'(ch);
        return {t, w[28:0]};
    endfunction

    task automatic do_reset;
        RST_N = 1'b0; WRITE_REQ = '0; HOLD_REQ = '0; CH_EN = '1;
        READY_OUT = 1'b1; CNT_CLR = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_reset;
        RST_N = 1'b0; WRITE_REQ = '1; HOLD_REQ = '0; CH_EN = '1;
        READY_OUT = 1'b1; CNT_CLR = 1'b0;
        #1;
        n_checks++; if (READ_GRANT !== 7'b0) begin n_fail++; $display("FAIL reset_grant: got %b want 0", READ_GRANT); end
        @(negedge CLK); @(negedge CLK); #1;
        n_checks++; if (WRITE_OUT !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b want 0", WRITE_OUT); end
        n_checks++; if (DATA_OUT !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", DATA_OUT); end
        n_checks++; if (OWNER !== 4'd6) begin n_fail++; $display("FAIL reset_owner: got %0d want 6", OWNER); end
        n_checks++; if (LOCKED !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", LOCKED); end
        n_checks++; if (WORD_CNT !== 4'h0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", WORD_CNT); end
        @(negedge CLK);
    endtask

    task automatic test_round_robin;
        int exp_ch, prev_ch;
        do_reset();
        WRITE_REQ = '1;
        prev_ch = 0;
        for (int t = 0; t < 29; t++) begin
            exp_ch = (t / 4) % 7;
            #1;
            n_checks++;
            if (READ_GRANT !== 7'(1 << exp_ch)) begin
                n_fail++; $display("FAIL rr_grant t=%0d: got %b want ch%0d", t, READ_GRANT, exp_ch);
            end
            if (t > 0) begin
                n_checks++;
                if (WRITE_OUT !== 1'b1 || DATA_OUT !== exp_word(prev_ch)) begin
                    n_fail++; $display("FAIL rr_out t=%0d: got %b/%h want 1/%h", t, WRITE_OUT, DATA_OUT, exp_word(prev_ch));
                end
            end
            prev_ch = exp_ch;
            @(negedge CLK);
        end
        #1;
        n_checks++; if (WORD_CNT !== 4'hF) begin n_fail++; $display("FAIL cnt_sat: got %h want f", WORD_CNT); end
        CNT_CLR = 1'b1;
        #1;
        n_checks++; if (READ_GRANT !== 7'b0000001) begin n_fail++; $display("FAIL clr_grant: got %b want 0000001", READ_GRANT); end
        @(negedge CLK);
        CNT_CLR = 1'b0;
        #1;
        n_checks++; if (WORD_CNT !== 4'h0) begin n_fail++; $display("FAIL cnt_clr: got %h want 0", WORD_CNT); end
        @(negedge CLK); #1;
        n_checks++; if (WORD_CNT !== 4'h1) begin n_fail++; $display("FAIL cnt_after_clr: got %h want 1", WORD_CNT); end
        @(negedge CLK);
    endtask

    task automatic test_hold;
        logic [6:0] exp_g;
        do_reset();
        for (int t = 0; t < 17; t++) begin
            WRITE_REQ = 7'b0100000;
            WRITE_REQ[2] = (t < 10) || (t == 13) || (t == 14);
            HOLD_REQ  = (t < 15) ? 7'b0000100 : 7'b0;
            if (t < 10 || t == 13 || t == 14) exp_g = 7'b0000100;
            else if (t >= 15)                 exp_g = 7'b0100000;
            else                              exp_g = 7'b0;
            #1;
            n_checks++;
            if (READ_GRANT !== exp_g) begin
                n_fail++; $display("FAIL hold_grant t=%0d: got %b want %b", t, READ_GRANT, exp_g);
            end
            if (t == 11) begin
                n_checks++;
                if (LOCKED !== 1'b1 || OWNER !== 4'd2) begin
                    n_fail++; $display("FAIL hold_wait: got locked=%b owner=%0d want 1/2", LOCKED, OWNER);
                end
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_backpressure;
        logic       rdy [7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [6:0] exp_g [7] = '{7'b0000010, 7'b0, 7'b0, 7'b0000010, 7'b0000010, 7'b0000010, 7'b0001000};
        logic       prev_w;
        do_reset();
        WRITE_REQ = 7'b0001010;
        prev_w = 1'b0;
        for (int t = 0; t < 7; t++) begin
            READY_OUT = rdy[t];
            #1;
            n_checks++;
            if (READ_GRANT !== exp_g[t] || WRITE_OUT !== prev_w) begin
                n_fail++; $display("FAIL bp t=%0d: got grant=%b wr=%b want %b/%b", t, READ_GRANT, WRITE_OUT, exp_g[t], prev_w);
            end
            prev_w = (exp_g[t] != 7'b0);
            @(negedge CLK);
        end
        READY_OUT = 1'b1;
    endtask

    task automatic test_enable_mask;
        int order [6] = '{0, 1, 3, 4, 5, 6};
        do_reset();
        CH_EN = 7'b1111011;
        WRITE_REQ = '1;
        for (int t = 0; t < 24; t++) begin
            #1;
            n_checks++;
            if (READ_GRANT !== 7'(1 << order[t / 4])) begin
                n_fail++; $display("FAIL mask_grant t=%0d: got %b want ch%0d", t, READ_GRANT, order[t / 4]);
            end
            @(negedge CLK);
        end
        do_reset();
        WRITE_REQ = 7'b0011000;
        for (int t = 0; t < 4; t++) begin
            CH_EN = (t >= 2) ? 7'b1110111 : 7'b1111111;
            #1;
            n_checks++;
            if (READ_GRANT !== ((t < 2) ? 7'b0001000 : 7'b0010000)) begin
                n_fail++; $display("FAIL en_drop t=%0d: got %b want %b", t, READ_GRANT, (t < 2) ? 7'b0001000 : 7'b0010000);
            end
            @(negedge CLK);
        end
        CH_EN = '1;
    endtask

    task automatic test_tag;
        do_reset();
        DATA_IN[5*32 +: 32] = 32'hFFFF_FFFF;
        WRITE_REQ = 7'b0100000;
        #1;
        n_checks++; if (READ_GRANT !== 7'b0100000) begin n_fail++; $display("FAIL tag_grant: got %b want 0100000", READ_GRANT); end
        @(negedge CLK);
        WRITE_REQ = '0;
        #1;
        n_checks++; if (WRITE_OUT !== 1'b1 || DATA_OUT !== 32'hBFFF_FFFF) begin
            n_fail++; $display("FAIL tag_data: got %b/%h want 1/bfffffff", WRITE_OUT, DATA_OUT);
        end
        n_checks++; if (READ_GRANT !== 7'b0) begin n_fail++; $display("FAIL tag_nogrant: got %b want 0", READ_GRANT); end
        @(negedge CLK); #1;
        n_checks++; if (WRITE_OUT !== 1'b0 || DATA_OUT !== 32'hBFFF_FFFF) begin
            n_fail++; $display("FAIL tag_hold: got %b/%h want 0/bfffffff", WRITE_OUT, DATA_OUT);
        end
        n_checks++; if (LOCKED !== 1'b0 || OWNER !== 4'd5) begin
            n_fail++; $display("FAIL tag_idle: got locked=%b owner=%0d want 0/5", LOCKED, OWNER);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset_mid_burst;
        do_reset();
        WRITE_REQ = '1;
        for (int t = 0; t < 2; t++) begin
            #1;
            n_checks++; if (READ_GRANT !== 7'b0000001) begin n_fail++; $display("FAIL mid_pre t=%0d: got %b want 0000001", t, READ_GRANT); end
            @(negedge CLK);
        end
        RST_N = 1'b0;
        #1;
        n_checks++; if (READ_GRANT !== 7'b0) begin n_fail++; $display("FAIL mid_rst_grant: got %b want 0", READ_GRANT); end
        @(negedge CLK); #1;
        n_checks++; if (WRITE_OUT !== 1'b0 || READ_GRANT !== 7'b0) begin
            n_fail++; $display("FAIL mid_rst_out: got wr=%b grant=%b want 0/0", WRITE_OUT, READ_GRANT);
        end
        n_checks++; if (OWNER !== 4'd6 || LOCKED !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_state: got owner=%0d locked=%b want 6/0", OWNER, LOCKED);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        n_checks++; if (READ_GRANT !== 7'b0000001) begin n_fail++; $display("FAIL mid_restart: got %b want 0000001", READ_GRANT); end
        @(negedge CLK);
    endtask

    initial begin
        for (int i = 0; i < 7; i++) DATA_IN[i*32 +: 32] = 32'h1357_0000 + 32'(i * 17);
        RST_N = 1'b0; CH_EN = '1; WRITE_REQ = '0; HOLD_REQ = '0;
        READY_OUT = 1'b1; CNT_CLR = 1'b0;
        @(negedge CLK);
        test_reset();
        test_round_robin();
        test_hold();
        test_backpressure();
        test_enable_mask();
        test_tag();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
